// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive bit path.
package usb_rx_pkg;
  localparam logic USB_J_LEVEL    = 1'b1;
  localparam int   USB_ONES_LIMIT = 6;
  localparam int   USB_BYTE_W     = 8;
  typedef logic [USB_BYTE_W-1:0] usb_byte_t;
endpackage

// File: rtl/usb_nrzi_decoder.sv
// NRZI decoder: an unchanged line level decodes to 1 and a toggle decodes to 0.
module usb_nrzi_decoder
  import usb_rx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit_strobe,
  input  logic i_d_plus,
  input  logic i_rcving,
  output logic o_dec_bit,
  output logic o_dec_stb
);

  logic r_prev_d;

  // Idle parks the reference level at J so the first strobe of a packet decodes against J.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_rcving)
      r_prev_d <= USB_J_LEVEL;
    else if (i_bit_strobe)
      r_prev_d <= i_d_plus;
  end

  assign o_dec_bit = ~(i_d_plus ^ r_prev_d);
  assign o_dec_stb = i_bit_strobe & i_rcving;

endmodule

// File: rtl/usb_rx_unstuffer.sv
// Receive bit unstuffer: drops stuff bits, flags stuffing violations, and packs data bits LSB-first into bytes.
module usb_rx_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int ONES_LIMIT = USB_ONES_LIMIT
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_bit_strobe,
  input  logic      i_d_plus,
  input  logic      i_rcving,
  output logic      o_bit_valid,
  output logic      o_d_orig,
  output logic      o_stuff_skip,
  output logic      o_stuff_err,
  output usb_byte_t o_rx_byte,
  output logic      o_byte_ready
);

  localparam logic [2:0] LIM = 3'(ONES_LIMIT);

  logic      w_dec_bit;
  logic      w_dec_stb;
  logic [2:0] r_ones_cnt;
  logic [2:0] r_bit_cnt;
  usb_byte_t r_shreg;
  usb_byte_t w_shreg_nxt;
  usb_byte_t r_rx_byte;
  logic      r_bit_valid;
  logic      r_d_orig;
  logic      r_stuff_skip;
  logic      r_stuff_err;
  logic      r_byte_ready;

  usb_nrzi_decoder u_nrzi (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_bit_strobe (i_bit_strobe),
    .i_d_plus     (i_d_plus),
    .i_rcving     (i_rcving),
    .o_dec_bit    (w_dec_bit),
    .o_dec_stb    (w_dec_stb)
  );

  assign w_shreg_nxt = {w_dec_bit, r_shreg[USB_BYTE_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ones_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_rx_byte    <= '0;
      r_bit_valid  <= 1'b0;
      r_d_orig     <= 1'b0;
      r_stuff_skip <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_byte_ready <= 1'b0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_stuff_skip <= 1'b0;
      r_byte_ready <= 1'b0;
      if (!i_rcving) begin
        // Any partial byte is abandoned; rx_byte keeps the last complete byte.
        r_ones_cnt  <= '0;
        r_bit_cnt   <= '0;
        r_stuff_err <= 1'b0;
      end else if (w_dec_stb) begin
        if (r_ones_cnt != LIM) begin
          r_ones_cnt  <= w_dec_bit ? r_ones_cnt + 3'd1 : 3'd0;
          r_bit_valid <= 1'b1;
          r_d_orig    <= w_dec_bit;
          r_shreg     <= w_shreg_nxt;
          r_bit_cnt   <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_byte    <= w_shreg_nxt;
            r_byte_ready <= 1'b1;
          end
        end else if (!w_dec_bit) begin
          r_stuff_skip <= 1'b1;
          r_ones_cnt   <= '0;
        end else begin
          // Violation: counter holds at the limit so the next 0 is still taken as the stuff bit.
          r_stuff_err <= 1'b1;
        end
      end
    end
  end

  assign o_bit_valid  = r_bit_valid;
  assign o_d_orig     = r_d_orig;
  assign o_stuff_skip = r_stuff_skip;
  assign o_stuff_err  = r_stuff_err;
  assign o_rx_byte    = r_rx_byte;
  assign o_byte_ready = r_byte_ready;

endmodule
